// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per clock on unsigned magnitudes; signs are fixed up at the end.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [CW-1:0]    count_reg;
    logic             is_div_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [WIDTH-1:0] mag_reg;
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // op[0]=0 selects the signed variants
    assign a_neg  = ~op[0] & src_a[WIDTH-1];
    assign b_neg  = ~op[0] & src_b[WIDTH-1];
    assign b_zero = (src_b == '0);
    assign abs_a  = a_neg ? -src_a : src_a;
    assign abs_b  = b_neg ? -src_b : src_b;

    // Multiply: acc_lo holds the remaining multiplier bits, product shifts in from the top
    assign mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mag_reg} : '0);

    // Divide: remainder in acc_hi, dividend bits shift out of acc_lo as quotient bits shift in
    assign div_trial = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, mag_reg});
    assign div_sub   = div_trial[WIDTH-1:0] - mag_reg;

    assign prod     = {acc_hi_reg, acc_lo_reg};
    assign prod_fix = neg_q_reg ? -prod : prod;
    assign quot_fix = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
    assign rem_fix  = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
    assign res_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div_reg ? quot_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            mag_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (hi_we) hi_reg <= wd;
                    if (lo_we) lo_reg <= wd;
                    if (start) begin
                        state_reg  <= S_RUN;
                        count_reg  <= '0;
                        is_div_reg <= op[1];
                        // A zero divisor must leave the all-ones quotient uncorrected
                        neg_q_reg  <= (a_neg ^ b_neg) & ~(op[1] & b_zero);
                        neg_r_reg  <= a_neg;
                        mag_reg    <= op[1] ? abs_b : abs_a;
                        acc_hi_reg <= '0;
                        acc_lo_reg <= op[1] ? abs_a : abs_b;
                    end
                end
                S_RUN: begin
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == LAST) state_reg <= S_FINISH;
                    if (is_div_reg) begin
                        acc_hi_reg <= div_ge ? div_sub : div_trial[WIDTH-1:0];
                        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi_reg <= mul_sum[WIDTH:1];
                        acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
                    end
                end
                S_FINISH: begin
                    hi_reg    <= res_hi;
                    lo_reg    <= res_lo;
                    done_reg  <= 1'b1;
                    count_reg <= '0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit: results, latency, busy/done timing, MTHI/MTLO and reset.
// Expected HI/LO pairs are queued when an operation is issued and popped when done pulses.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wd = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        longint sa;
        longint sb_v;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb_v); eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (b == 0) begin eh = a; el = '1; end
                else begin el = W'(sa / sb_v); eh = W'(sa % sb_v); end
            end
            default: begin
                if (b == 0) begin eh = a; el = '1; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endfunction

    // Drive start for one edge (the accept edge) and queue the expected result.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        e.hi = eh; e.lo = el; e.op = o; e.a = a; e.b = b;
        sb.push_back(e);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // action 1: spurious start at cycle 'at'; action 2: MTHI write at cycle 'at', hi must stay hold_hi
    task automatic wait_done(input string tag, input int action, input int at, input logic [W-1:0] hold_hi);
        int n;
        int busy_cnt;
        exp_t e;
        n = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) busy_cnt++;
            start = 1'b0;
            hi_we = 1'b0;
            if (action == 1 && n == at) begin
                start = 1'b1; op = 2'b01; src_a = 32'd1; src_b = 32'd1;
            end
            if (action == 2 && n == at) begin
                hi_we = 1'b1; wd = 32'h1234;
            end
            if (action == 2 && n == at + 1) check({tag, "_mthi_busy"}, 64'(hi), 64'(hold_hi));
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        check({tag, "_done_seen"}, 64'(n < 60), 64'(1));
        check({tag, "_latency"}, 64'(n), 64'(33));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(33));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_hi"}, 64'(hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(lo), 64'(e.lo));
            $display("[TB] %s op=%0d a=%h b=%h hi=%h lo=%h exp_hi=%h exp_lo=%h lat=%0d",
                     tag, e.op, e.a, e.b, hi, lo, e.hi, e.lo, n);
        end
    endtask

    initial begin
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [1:0]   ro;

        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_done("multu_max", 0, 0, '0);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'(0));

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        wait_done("mult_neg", 0, 0, '0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div_neg", 0, 0, '0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        wait_done("div_ovf", 0, 0, '0);
        issue(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        wait_done("divu_zero", 0, 0, '0);
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_done("divu_100_7", 0, 0, '0);
        issue(2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF);
        wait_done("div_neg_zero", 0, 0, '0);

        // Spurious start mid-run, then a back-to-back start in the done cycle
        model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, eh, el);
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, eh, el);
        wait_done("multu_ignore_start", 1, 10, '0);
        model(2'b00, 32'h8765_4321, 32'h0000_1F3D, eh, el);
        issue(2'b00, 32'h8765_4321, 32'h0000_1F3D, eh, el);
        wait_done("mult_back2back", 0, 0, '0);

        // MTHI while busy is dropped; hi still holds the previous result
        issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
        wait_done("multu_mthi_busy", 2, 5, eh);

        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h0000_ABCD;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h0000_ABCD);
        check("mtlo_idle", 64'(lo), 64'h0000_ABCD);
        $display("[TB] mthi_mtlo wd=%h hi=%h lo=%h", wd, hi, lo);

        // Asynchronous reset in the middle of a divide
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        repeat (14) begin
            @(posedge clk); #1;
        end
        check("midrun_busy_before", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 64'(busy), 64'(0));
        check("midrun_rst_done", 64'(done), 64'(0));
        check("midrun_rst_hi", 64'(hi), 64'(0));
        check("midrun_rst_lo", 64'(lo), 64'(0));
        $display("[TB] async_reset busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        sb.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 64'(busy), 64'(0));
        issue(2'b10, 32'd1000, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FF72);
        wait_done("div_after_rst", 0, 0, '0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50));
            model(ro, ra, rb, eh, el);
            issue(ro, ra, rb, eh, el);
            wait_done($sformatf("rand%0d", i), 0, 0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
